// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the arbiter and the uart transmit side.
// Handshake: a requester holds req_valid/req_data/req_last stable until it sees its req_ready bit; the byte transfers on the rising edge where both are high.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_busy;
    logic [7:0]        timeout_cnt;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data, tx_wr, timeout_cnt
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data, tx_wr, timeout_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one uart transmitter among NREQ byte streams.
// Every output is registered; the FSM state is exported on fsm_state for observation.
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int BUSY_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_arbiter_if.slave        bus,
    output logic [2:0]              fsm_state
);
    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WRITE   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant, grant_nxt;
    logic [NREQ-1:0] ready, ready_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   rr, rr_nxt;
    logic [7:0]      data_q, data_nxt;
    logic [7:0]      tcnt, tcnt_nxt;
    logic            wr, wr_nxt;
    logic            last_q, last_nxt;
    logic [WW-1:0]   wcnt, wcnt_nxt;
    logic            byte_done;

    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            pick_found;
    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;

    // Scan downward so the candidate closest to the rr pointer is written last and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ready_nxt = '0;
        owner_nxt = owner;
        rr_nxt    = rr;
        data_nxt  = data_q;
        tcnt_nxt  = tcnt;
        wr_nxt    = 1'b0;
        last_nxt  = last_q;
        wcnt_nxt  = wcnt;
        byte_done = 1'b0;

        case (state)
            IDLE: begin
                if (grant == '0) begin
                    if (pick_found) begin
                        grant_nxt = NREQ'(1) << pick_idx;
                        ready_nxt = NREQ'(1) << pick_idx;
                        owner_nxt = pick_idx;
                        state_nxt = LOAD;
                    end
                end else if (owner_valid) begin
                    ready_nxt = grant;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                data_nxt  = owner_data;
                last_nxt  = owner_last;
                wr_nxt    = !bus.tx_busy;
                state_nxt = WRITE;
            end
            WRITE: begin
                // Parked here with the strobe low while the uart is still busy elsewhere.
                if (wr) begin
                    wcnt_nxt  = '0;
                    state_nxt = WAIT_HI;
                end else begin
                    wr_nxt = !bus.tx_busy;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (wcnt == WW'(BUSY_WAIT - 1)) begin
                    if (tcnt != 8'hFF) begin
                        tcnt_nxt = tcnt + 8'd1;
                    end
                    byte_done = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (byte_done) begin
            state_nxt = IDLE;
            if (last_q) begin
                grant_nxt = '0;
                rr_nxt    = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            ready  <= '0;
            owner  <= '0;
            rr     <= '0;
            data_q <= 8'h00;
            tcnt   <= 8'h00;
            wr     <= 1'b0;
            last_q <= 1'b0;
            wcnt   <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            ready  <= ready_nxt;
            owner  <= owner_nxt;
            rr     <= rr_nxt;
            data_q <= data_nxt;
            tcnt   <= tcnt_nxt;
            wr     <= wr_nxt;
            last_q <= last_nxt;
            wcnt   <= wcnt_nxt;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.grant       = grant;
    assign bus.tx_data     = data_q;
    assign bus.tx_wr       = wr;
    assign bus.timeout_cnt = tcnt;
    assign fsm_state       = state;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(ready));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a small uart busy model, logs of tx_wr / req_ready
// activity, and one task per scenario with hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 2;
    localparam int BUSY_WAIT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] fsm_state;

    int tests_run = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int busy_cnt  = 0;
    int busy_len  = 4;
    bit model_en  = 1'b1;
    int overlap_cnt = 0;

    logic [7:0]      exp_q[$];
    logic [7:0]      wr_data_q[$];
    int              wr_cyc_q[$];
    logic [NREQ-1:0] rdy_q[$];
    logic [NREQ-1:0] gnt_q[$];

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    // uart model: busy rises the cycle after tx_wr and stays high for busy_len cycles
    initial forever begin
        @(negedge clk);
        if (model_en) begin
            logic busy_now;
            busy_now = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (bus.tx_wr) busy_cnt = busy_len;
            bus.tx_busy = busy_now;
        end
    end

    // activity monitor
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (bus.tx_wr) begin
            wr_data_q.push_back(bus.tx_data);
            wr_cyc_q.push_back(cyc);
            if (bus.tx_busy) overlap_cnt++;
        end
        if (bus.req_ready != '0) begin
            rdy_q.push_back(bus.req_ready);
            gnt_q.push_back(bus.grant);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        model_en = 1'b0;
        busy_cnt = 0;
        bus.tx_busy = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_en = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        exp_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rdy_q.delete();
        gnt_q.delete();
        overlap_cnt = 0;
    endtask

    task automatic send_byte(input int idx, input logic [7:0] data, input logic last);
        bit seen;
        seen = 1'b0;
        bus.req_data[8*idx +: 8] = data;
        bus.req_last[idx]  = last;
        bus.req_valid[idx] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (bus.req_ready[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            fail_cnt++;
            $display("FAIL send_byte_ready req%0d: got no req_ready within 300 cycles, expected a pulse", idx);
        end
        tick();
        bus.req_valid[idx] = 1'b0;
        bus.req_last[idx]  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (fsm_state == 3'd0 && bus.grant == '0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!done) begin
            fail_cnt++;
            $display("FAIL %s_idle: state=%0d grant=%b, expected state 0 grant 00", name, fsm_state, bus.grant);
        end
    endtask

    task automatic check_writes(input string name);
        tests_run++;
        if (wr_data_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL %s_wr_count: got %0d tx_wr pulses, expected %0d", name, wr_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            tests_run++;
            if (wr_data_q[i] !== exp_q[i]) begin
                fail_cnt++;
                $display("FAIL %s_wr_data[%0d]: got %h, expected %h", name, i, wr_data_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.grant !== 2'b00)    begin fail_cnt++; $display("FAIL reset_grant: got %b, expected 00", bus.grant); end
        tests_run++;
        if (bus.req_ready !== 2'b00) begin fail_cnt++; $display("FAIL reset_ready: got %b, expected 00", bus.req_ready); end
        tests_run++;
        if (bus.tx_wr !== 1'b0)      begin fail_cnt++; $display("FAIL reset_tx_wr: got %b, expected 0", bus.tx_wr); end
        tests_run++;
        if (bus.tx_data !== 8'h00)   begin fail_cnt++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data); end
        tests_run++;
        if (bus.timeout_cnt !== 8'h00) begin fail_cnt++; $display("FAIL reset_timeout: got %h, expected 00", bus.timeout_cnt); end
        tests_run++;
        if (fsm_state !== 3'd0)      begin fail_cnt++; $display("FAIL reset_state: got %0d, expected 0", fsm_state); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        clear_logs();
        busy_len = 4;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h4F);
        send_byte(0, 8'h48, 1'b0);
        tests_run++;
        if (bus.grant !== 2'b01) begin fail_cnt++; $display("FAIL single_grant_locked: got %b, expected 01", bus.grant); end
        send_byte(0, 8'h4F, 1'b1);
        wait_idle("single");
        check_writes("single");
        tests_run++;
        if (rdy_q.size() !== 2) begin fail_cnt++; $display("FAIL single_ready_count: got %0d, expected 2", rdy_q.size()); end
        for (int i = 0; i < rdy_q.size(); i++) begin
            tests_run++;
            if (rdy_q[i] !== 2'b01) begin fail_cnt++; $display("FAIL single_ready[%0d]: got %b, expected 01", i, rdy_q[i]); end
        end
        tests_run++;
        if (bus.tx_data !== 8'h4F) begin fail_cnt++; $display("FAIL single_tx_data_hold: got %h, expected 4f", bus.tx_data); end
        tests_run++;
        if (bus.timeout_cnt !== 8'h00) begin fail_cnt++; $display("FAIL single_timeout: got %h, expected 00", bus.timeout_cnt); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy[3];
        do_reset();
        clear_logs();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h12);
        exp_rdy[0] = 2'b01;
        exp_rdy[1] = 2'b10;
        exp_rdy[2] = 2'b01;
        fork
            begin
                send_byte(0, 8'h11, 1'b1);
                send_byte(0, 8'h12, 1'b1);
            end
            send_byte(1, 8'h21, 1'b1);
        join
        wait_idle("rr");
        check_writes("rr");
        tests_run++;
        if (rdy_q.size() !== 3) begin fail_cnt++; $display("FAIL rr_ready_count: got %0d, expected 3", rdy_q.size()); end
        for (int i = 0; i < 3 && i < rdy_q.size(); i++) begin
            tests_run++;
            if (rdy_q[i] !== exp_rdy[i]) begin fail_cnt++; $display("FAIL rr_order[%0d]: got %b, expected %b", i, rdy_q[i], exp_rdy[i]); end
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] exp_rdy[4];
        clear_logs();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h55);
        exp_rdy[0] = 2'b01;
        exp_rdy[1] = 2'b01;
        exp_rdy[2] = 2'b01;
        exp_rdy[3] = 2'b10;
        fork
            begin
                send_byte(0, 8'hA1, 1'b0);
                send_byte(0, 8'hA2, 1'b0);
                send_byte(0, 8'hA3, 1'b1);
            end
            begin
                repeat (2) tick();
                send_byte(1, 8'h55, 1'b1);
            end
        join
        wait_idle("lock");
        check_writes("lock");
        tests_run++;
        if (rdy_q.size() !== 4) begin fail_cnt++; $display("FAIL lock_ready_count: got %0d, expected 4", rdy_q.size()); end
        for (int i = 0; i < 4 && i < rdy_q.size(); i++) begin
            tests_run++;
            if (rdy_q[i] !== exp_rdy[i]) begin fail_cnt++; $display("FAIL lock_ready[%0d]: got %b, expected %b", i, rdy_q[i], exp_rdy[i]); end
            tests_run++;
            if (gnt_q[i] !== exp_rdy[i]) begin fail_cnt++; $display("FAIL lock_grant[%0d]: got %b, expected %b", i, gnt_q[i], exp_rdy[i]); end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        busy_len = 0;
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        send_byte(0, 8'hC1, 1'b0);
        send_byte(0, 8'hC2, 1'b1);
        wait_idle("timeout");
        check_writes("timeout");
        tests_run++;
        if (bus.timeout_cnt !== 8'd2) begin fail_cnt++; $display("FAIL timeout_count: got %0d, expected 2", bus.timeout_cnt); end
        if (wr_cyc_q.size() >= 2) begin
            tests_run++;
            if (wr_cyc_q[1] - wr_cyc_q[0] !== 11) begin
                fail_cnt++;
                $display("FAIL timeout_spacing: got %0d cycles between tx_wr, expected 11", wr_cyc_q[1] - wr_cyc_q[0]);
            end
        end
        busy_len = 4;
    endtask

    task automatic test_busy_hold();
        clear_logs();
        model_en = 1'b0;
        busy_cnt = 0;
        bus.tx_busy = 1'b1;
        exp_q.push_back(8'h77);
        send_byte(1, 8'h77, 1'b1);
        repeat (10) tick();
        tests_run++;
        if (wr_data_q.size() !== 0) begin fail_cnt++; $display("FAIL busy_hold_no_wr: got %0d tx_wr pulses, expected 0", wr_data_q.size()); end
        tests_run++;
        if (rdy_q.size() !== 1) begin fail_cnt++; $display("FAIL busy_hold_loaded: got %0d ready pulses, expected 1", rdy_q.size()); end
        tests_run++;
        if (fsm_state !== 3'd2) begin fail_cnt++; $display("FAIL busy_hold_state: got %0d, expected 2", fsm_state); end
        bus.tx_busy = 1'b0;
        model_en = 1'b1;
        wait_idle("busy_hold");
        check_writes("busy_hold");
        tests_run++;
        if (overlap_cnt !== 0) begin fail_cnt++; $display("FAIL busy_hold_overlap: got %0d tx_wr with busy high, expected 0", overlap_cnt); end
        tests_run++;
        if (bus.timeout_cnt !== 8'd2) begin fail_cnt++; $display("FAIL busy_hold_timeout: got %0d, expected 2", bus.timeout_cnt); end
    endtask

    task automatic test_reset_mid();
        bit reached;
        clear_logs();
        busy_len = 20;
        reached = 1'b0;
        send_byte(0, 8'h88, 1'b0);
        for (int n = 0; n < 50; n++) begin
            if (fsm_state == 3'd4) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!reached) begin fail_cnt++; $display("FAIL reset_mid_reach: state=%0d, expected 4", fsm_state); end
        bus.req_data[7:0] = 8'h99;
        bus.req_last[0]   = 1'b1;
        bus.req_valid[0]  = 1'b1;
        #2;
        reset = 1'b0;
        model_en = 1'b0;
        busy_cnt = 0;
        bus.tx_busy = 1'b0;
        #1;
        tests_run++;
        if (bus.grant !== 2'b00 || bus.req_ready !== 2'b00 || bus.tx_wr !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid_ctrl: grant=%b ready=%b tx_wr=%b, expected 00 00 0", bus.grant, bus.req_ready, bus.tx_wr);
        end
        tests_run++;
        if (bus.tx_data !== 8'h00 || fsm_state !== 3'd0 || bus.timeout_cnt !== 8'h00) begin
            fail_cnt++;
            $display("FAIL reset_mid_data: tx_data=%h state=%0d timeout=%h, expected 00 0 00", bus.tx_data, fsm_state, bus.timeout_cnt);
        end
        repeat (2) tick();
        clear_logs();
        busy_len = 4;
        reset = 1'b1;
        model_en = 1'b1;
        exp_q.push_back(8'h99);
        send_byte(0, 8'h99, 1'b1);
        wait_idle("reset_mid");
        check_writes("reset_mid");
        tests_run++;
        if (gnt_q.size() !== 1) begin
            fail_cnt++;
            $display("FAIL reset_mid_ready_count: got %0d, expected 1", gnt_q.size());
        end else begin
            tests_run++;
            if (gnt_q[0] !== 2'b01) begin fail_cnt++; $display("FAIL reset_mid_grant: got %b, expected 01", gnt_q[0]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
